// File: rtl/vec_mem_initiator.sv
// Word-vector mover between a local word array and a PicoRV32-style native memory port.
// Define VEC_MEM_INITIATOR_BOUNDS_EN to reject transfers that leave the MEM_BYTES window.
module vec_mem_initiator #(
   parameter int MAX_WORDS = 16,
   parameter int MEM_BYTES = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_store,
   input  logic [31:0]                  cmd_base,
   input  logic [8:0]                   cmd_nwords,
   output logic [$clog2(MAX_WORDS)-1:0] st_rd_idx,
   input  logic [31:0]                  st_rd_data,
   output logic                         ld_wr_en,
   output logic [$clog2(MAX_WORDS)-1:0] ld_wr_idx,
   output logic [31:0]                  ld_wr_data,
   output logic                         mem_valid,
   input  logic                         mem_ready,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [3:0]                   mem_wstrb,
   input  logic [31:0]                  mem_rdata,
   output logic                         done,
   output logic                         err
);

   localparam int IDX_W = $clog2(MAX_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic               store_r;
   logic [31:0]        addr_r;
   logic [8:0]         count_r;
   logic [8:0]         idx_r;
   logic               cmd_ready_r, mem_valid_r, done_r, ld_wr_en_r;
   logic [31:0]        mem_wdata_r, ld_wr_data_r;
   logic [3:0]         mem_wstrb_r;
   logic [IDX_W-1:0]   ld_wr_idx_r;

   logic [8:0]         count_s;
   logic [31:0]        waddr_s;
   logic               accept_s, hs_s, last_s, oob_s;

   assign count_s  = (cmd_nwords > 9'(MAX_WORDS)) ? 9'(MAX_WORDS) : cmd_nwords;
   assign waddr_s  = cmd_base & 32'hFFFF_FFFC;
   assign accept_s = (state_r == IDLE) && cmd_valid;
   assign hs_s     = (state_r == REQ) && mem_ready;
   assign last_s   = ((idx_r + 9'd1) == count_r);

`ifdef VEC_MEM_INITIATOR_BOUNDS_EN
   logic [32:0] end_s;
   logic        err_r;
   assign end_s = {1'b0, waddr_s} + {22'd0, count_s, 2'b00};
   assign oob_s = (end_s > 33'(MEM_BYTES));
   assign err   = err_r;

   // Error pulse coincides with the done pulse of a rejected command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_r <= 1'b0;
      end else begin
         err_r <= accept_s && oob_s;
      end
   end
`else
   assign oob_s = 1'b0;
   assign err   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; empty or rejected commands skip straight to DONE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               if ((count_s == 9'd0) || oob_s) begin
                  state_s = DONE;
               end else begin
                  state_s = REQ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (mem_ready) begin
               state_s = last_s ? DONE : GAP;
            end else begin
               state_s = REQ;
            end
         end
         GAP:     state_s = REQ;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Transfer bookkeeping and registered outputs, all derived from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         store_r      <= 1'b0;
         addr_r       <= 32'd0;
         count_r      <= 9'd0;
         idx_r        <= 9'd0;
         cmd_ready_r  <= 1'b1;
         mem_valid_r  <= 1'b0;
         done_r       <= 1'b0;
         mem_wdata_r  <= 32'd0;
         mem_wstrb_r  <= 4'b0000;
         ld_wr_en_r   <= 1'b0;
         ld_wr_idx_r  <= '0;
         ld_wr_data_r <= 32'd0;
      end else begin
         cmd_ready_r <= (state_s == IDLE);
         mem_valid_r <= (state_s == REQ);
         done_r      <= (state_s == DONE);
         ld_wr_en_r  <= 1'b0;
         if (accept_s) begin
            store_r     <= cmd_store;
            addr_r      <= waddr_s;
            count_r     <= count_s;
            idx_r       <= 9'd0;
            mem_wstrb_r <= cmd_store ? 4'b1111 : 4'b0000;
         end else if (hs_s) begin
            idx_r  <= idx_r + 9'd1;
            addr_r <= addr_r + 32'd4;
            if (!store_r) begin
               ld_wr_en_r   <= 1'b1;
               ld_wr_idx_r  <= idx_r[IDX_W-1:0];
               ld_wr_data_r <= mem_rdata;
            end
         end
         // st_rd_idx already points at the word about to be requested.
         if ((state_s == REQ) && (state_r != REQ)) begin
            mem_wdata_r <= st_rd_data;
         end
      end
   end

   assign st_rd_idx  = (state_r == IDLE) ? '0 : idx_r[IDX_W-1:0];
   assign cmd_ready  = cmd_ready_r;
   assign mem_valid  = mem_valid_r;
   assign mem_addr   = addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign mem_wstrb  = mem_wstrb_r;
   assign ld_wr_en   = ld_wr_en_r;
   assign ld_wr_idx  = ld_wr_idx_r;
   assign ld_wr_data = ld_wr_data_r;
   assign done       = done_r;

endmodule

// File: tb/tb_vec_mem_initiator.sv
// Self-checking bench for vec_mem_initiator: random memory responder plus a transaction-level
// model of the expected bus traffic, load writes, done/err timing and cmd_ready behaviour.
`timescale 1ns/1ps
module tb_vec_mem_initiator;
   localparam int MW   = 16;
   localparam int MEMB = 1024;

   logic        clk = 1'b0, reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_store = 1'b0;
   logic [31:0] cmd_base = 32'd0;
   logic [8:0]  cmd_nwords = 9'd0;
   logic [3:0]  st_rd_idx, ld_wr_idx;
   logic [31:0] st_rd_data, ld_wr_data, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        ld_wr_en, mem_valid, done, err;
   logic        mem_ready = 1'b0;
   logic [3:0]  mem_wstrb;
   logic [31:0] st_seed = 32'hA000_0000;

   typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic [3:0] wstrb;} xact_t;
   typedef struct {logic [3:0] idx; logic [31:0] data;} ldw_t;

   xact_t xact_q[$];
   ldw_t  ld_q[$];
   int    done_q[$], err_q[$], rise_q[$], pulse_q[$], dly_q[$];
   bit    ready_at[int];
   int    cyc = 0, stable_err = 0, vectors = 0, miscompares = 0;
   bit    ready_block = 1'b0, noise_en = 1'b0;

   vec_mem_initiator #(.MAX_WORDS(MW), .MEM_BYTES(MEMB)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
      .cmd_base(cmd_base), .cmd_nwords(cmd_nwords),
      .st_rd_idx(st_rd_idx), .st_rd_data(st_rd_data),
      .ld_wr_en(ld_wr_en), .ld_wr_idx(ld_wr_idx), .ld_wr_data(ld_wr_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .done(done), .err(err)
   );

   assign st_rd_data = st_seed + 32'(st_rd_idx);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: drives ready on the falling edge after a per-word delay from dly_q.
   always @(negedge clk) begin : resp
      int    wait_cnt;
      int    cur_dly;
      xact_t x;
      xact_t hold;
      if (reset) begin
         mem_ready = 1'b0;
         wait_cnt  = 0;
      end else if (mem_valid) begin
         if (wait_cnt == 0) begin
            cur_dly    = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
            hold.addr  = mem_addr;
            hold.wdata = mem_wdata;
            hold.wstrb = mem_wstrb;
         end else if (mem_addr !== hold.addr || mem_wdata !== hold.wdata || mem_wstrb !== hold.wstrb) begin
            stable_err++;
         end
         if (!ready_block && wait_cnt >= cur_dly) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            x.addr    = mem_addr;
            x.wdata   = mem_wdata;
            x.wstrb   = mem_wstrb;
            x.rdata   = mem_rdata;
            xact_q.push_back(x);
            wait_cnt  = 0;
         end else begin
            mem_ready = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         wait_cnt  = 0;
      end
   end

   // Output monitor: records pulses, load writes and valid-run timing per cycle.
   always @(negedge clk) begin : mon
      bit   prev_v;
      int   hi_run;
      ldw_t w;
      ready_at[cyc] = cmd_ready;
      if (done) done_q.push_back(cyc);
      if (err)  err_q.push_back(cyc);
      if (ld_wr_en) begin
         w.idx  = ld_wr_idx;
         w.data = ld_wr_data;
         ld_q.push_back(w);
      end
      if (mem_valid) begin
         if (!prev_v) rise_q.push_back(cyc);
         hi_run++;
      end else begin
         if (prev_v) pulse_q.push_back(hi_run);
         hi_run = 0;
      end
      prev_v = mem_valid;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      xact_q.delete(); ld_q.delete(); done_q.delete(); err_q.delete();
      rise_q.delete(); pulse_q.delete(); stable_err = 0;
   endtask

   // Issues one command and checks the whole resulting transfer against the model.
   task automatic run_transfer(input bit st, input logic [31:0] base, input logic [8:0] nw, input int fdly);
      int          cnt, n_exp, t_acc, exp_done, k, d, busy_bad, t_rise, got;
      logic [31:0] waddr, ea;
      bit          oob, rdy;
      int          dl[$];
      cnt   = (int'(nw) > MW) ? MW : int'(nw);
      waddr = base & 32'hFFFF_FFFC;
      oob   = 1'b0;
`ifdef VEC_MEM_INITIATOR_BOUNDS_EN
      oob = (64'(waddr) + 64'(4 * cnt)) > 64'(MEMB);
`endif
      n_exp = oob ? 0 : cnt;
      dly_q.delete();
      for (int i = 0; i < n_exp; i++) begin
         d = (fdly < 0) ? int'($urandom_range(0, 3)) : fdly;
         dl.push_back(d);
         dly_q.push_back(d);
      end
      clear_logs();
      cmd_store = st; cmd_base = base; cmd_nwords = nw; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin tick(); k++; end
      @(posedge clk); #1;
      t_acc = cyc;
      cmd_valid = 1'b0;
      exp_done = t_acc;
      for (int i = 0; i < n_exp; i++) exp_done += dl[i] + 1 + ((i > 0) ? 1 : 0);
      k = 0;
      while (done_q.size() == 0 && k < 3000) begin tick(); k++; end
      repeat (3) tick();

      vectors++;
      if (done_q.size() !== 1) begin miscompares++; $display("FAIL done_count: got %0d expected 1", done_q.size()); end
      got = (done_q.size() > 0) ? done_q[0] : -1;
      vectors++;
      if (got !== exp_done) begin miscompares++; $display("FAIL done_cycle: got %0d expected %0d", got, exp_done); end
      vectors++;
      if (err_q.size() !== int'(oob)) begin miscompares++; $display("FAIL err_count: got %0d expected %0d", err_q.size(), oob); end
      vectors++;
      if (xact_q.size() !== n_exp) begin miscompares++; $display("FAIL xact_count: got %0d expected %0d", xact_q.size(), n_exp); end
      for (int i = 0; i < n_exp && i < xact_q.size(); i++) begin
         ea = waddr + 32'(4 * i);
         vectors++;
         if (xact_q[i].addr !== ea) begin miscompares++; $display("FAIL addr[%0d]: got %h expected %h", i, xact_q[i].addr, ea); end
         vectors++;
         if (xact_q[i].wstrb !== (st ? 4'b1111 : 4'b0000)) begin miscompares++; $display("FAIL wstrb[%0d]: got %b expected %b", i, xact_q[i].wstrb, st ? 4'b1111 : 4'b0000); end
         if (st) begin
            vectors++;
            if (xact_q[i].wdata !== st_seed + 32'(i)) begin miscompares++; $display("FAIL wdata[%0d]: got %h expected %h", i, xact_q[i].wdata, st_seed + 32'(i)); end
         end
      end
      vectors++;
      if (ld_q.size() !== (st ? 0 : n_exp)) begin miscompares++; $display("FAIL ld_count: got %0d expected %0d", ld_q.size(), st ? 0 : n_exp); end
      for (int i = 0; i < ld_q.size() && i < xact_q.size(); i++) begin
         vectors++;
         if (ld_q[i].idx !== 4'(i) || ld_q[i].data !== xact_q[i].rdata) begin
            miscompares++;
            $display("FAIL ld_write[%0d]: got idx %0d data %h expected idx %0d data %h", i, ld_q[i].idx, ld_q[i].data, i, xact_q[i].rdata);
         end
      end
      vectors++;
      if (rise_q.size() !== n_exp || pulse_q.size() !== n_exp) begin
         miscompares++; $display("FAIL valid_pulses: got %0d/%0d expected %0d", rise_q.size(), pulse_q.size(), n_exp);
      end
      t_rise = t_acc;
      for (int i = 0; i < n_exp && i < rise_q.size() && i < pulse_q.size(); i++) begin
         vectors++;
         if (rise_q[i] !== t_rise || pulse_q[i] !== dl[i] + 1) begin
            miscompares++;
            $display("FAIL valid_timing[%0d]: got rise %0d len %0d expected rise %0d len %0d", i, rise_q[i], pulse_q[i], t_rise, dl[i] + 1);
         end
         t_rise += dl[i] + 2;
      end
      vectors++;
      if (stable_err !== 0) begin miscompares++; $display("FAIL req_stable: got %0d changes expected 0", stable_err); end
      busy_bad = 0;
      for (int c = t_acc; c <= exp_done; c++) if (ready_at.exists(c) && ready_at[c]) busy_bad++;
      vectors++;
      if (busy_bad !== 0) begin miscompares++; $display("FAIL cmd_ready_busy: got %0d high cycles expected 0", busy_bad); end
      rdy = ready_at.exists(exp_done + 1) ? ready_at[exp_done + 1] : 1'b0;
      vectors++;
      if (rdy !== 1'b1) begin miscompares++; $display("FAIL cmd_ready_after_done: got %b expected 1", rdy); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      vectors++;
      if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== 69'd0) begin
         miscompares++; $display("FAIL reset_mem: got %b %h %h %b expected all zero", mem_valid, mem_addr, mem_wdata, mem_wstrb);
      end
      vectors++;
      if ({ld_wr_en, ld_wr_idx, ld_wr_data, done, err, st_rd_idx} !== 43'd0) begin
         miscompares++; $display("FAIL reset_misc: got %b %0d %h %b %b %0d expected all zero", ld_wr_en, ld_wr_idx, ld_wr_data, done, err, st_rd_idx);
      end
      vectors++;
      if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      reset = 1'b0;
      repeat (2) tick();
      vectors++;
      if (cmd_ready !== 1'b1 || mem_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL post_reset: got ready %b valid %b done %b expected 1 0 0", cmd_ready, mem_valid, done);
      end
   endtask

   task automatic test_load();
      run_transfer(1'b0, 32'h0000_03BC, 9'd4, 1);
   endtask

   task automatic test_store();
      st_seed = 32'hA000_0000;
      run_transfer(1'b1, 32'h0000_0320, 9'd2, 1);
   endtask

   task automatic test_count_edges();
      run_transfer(1'b0, 32'h0000_0100, 9'd0, -1);
      run_transfer(1'b0, 32'h0000_0000, 9'd300, -1);
      run_transfer(1'b1, 32'h0000_0040, 9'd1, 0);
   endtask

   task automatic test_bounds_and_wrap();
      run_transfer(1'b0, 32'h0000_03F8, 9'd4, -1);
      st_seed = 32'h1234_5670;
      run_transfer(1'b1, 32'hFFFF_FFF9, 9'd4, 0);
   endtask

   task automatic test_random();
      logic [31:0] b;
      logic [8:0]  n;
      noise_en = 1'b1;
      for (int t = 0; t < 40; t++) begin
         st_seed = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
         n = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(17, 511)) : 9'($urandom_range(0, 17));
         run_transfer(1'($urandom_range(0, 1)), b, n, -1);
      end
      noise_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int k;
      ready_block = 1'b1;
      dly_q.delete();
      clear_logs();
      cmd_store = 1'b0; cmd_base = 32'h0000_0040; cmd_nwords = 9'd4; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin tick(); k++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) tick();
      vectors++;
      if (mem_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got %b expected 1", mem_valid); end
      reset = 1'b1;
      #1;
      vectors++;
      if (mem_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++; $display("FAIL async_reset: got valid %b ready %b expected 0 1", mem_valid, cmd_ready);
      end
      repeat (2) tick();
      reset = 1'b0;
      ready_block = 1'b0;
      repeat (3) tick();
      vectors++;
      if (done_q.size() !== 0 || cmd_ready !== 1'b1) begin
         miscompares++; $display("FAIL abandoned_xfer: got done %0d ready %b expected 0 1", done_q.size(), cmd_ready);
      end
      run_transfer(1'b0, 32'h0000_0040, 9'd4, -1);
   endtask

   task automatic test_back_to_back();
      int k, t_a, t_b, exp_a, got;
      st_seed = 32'h5A5A_0000;
      dly_q.delete();
      dly_q.push_back(0); dly_q.push_back(0); dly_q.push_back(0);
      clear_logs();
      cmd_store = 1'b0; cmd_base = 32'h0000_0080; cmd_nwords = 9'd2; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin tick(); k++; end
      @(posedge clk); #1;
      t_a = cyc;
      cmd_store = 1'b1; cmd_base = 32'h0000_0200; cmd_nwords = 9'd1;
      k = 0;
      while (!cmd_ready && k < 100) begin tick(); k++; end
      @(posedge clk); #1;
      t_b = cyc;
      cmd_valid = 1'b0;
      k = 0;
      while (done_q.size() < 2 && k < 200) begin tick(); k++; end
      repeat (3) tick();
      exp_a = t_a + 3;
      vectors++;
      if (t_b !== exp_a + 2) begin miscompares++; $display("FAIL b2b_accept: got %0d expected %0d", t_b, exp_a + 2); end
      got = (done_q.size() > 1) ? done_q[1] : -1;
      vectors++;
      if (done_q.size() !== 2 || got !== t_b + 1) begin
         miscompares++; $display("FAIL b2b_done: got count %0d cycle %0d expected 2 %0d", done_q.size(), got, t_b + 1);
      end
      vectors++;
      if (xact_q.size() !== 3) begin
         miscompares++; $display("FAIL b2b_xacts: got %0d expected 3", xact_q.size());
      end else if (xact_q[2].addr !== 32'h0000_0200 || xact_q[2].wdata !== st_seed || xact_q[2].wstrb !== 4'b1111) begin
         miscompares++; $display("FAIL b2b_store: got %h %h %b expected 00000200 %h 1111", xact_q[2].addr, xact_q[2].wdata, xact_q[2].wstrb, st_seed);
      end
      vectors++;
      if (ld_q.size() !== 2) begin miscompares++; $display("FAIL b2b_loads: got %0d expected 2", ld_q.size()); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_count_edges();
      test_bounds_and_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
